bcd_result_converter: RTL

- Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) directly downstream of the parameterised fullAdder.
- Consumes the adder's sum (and carry-out in unsigned mode) and produces sign plus packed BCD digits for the seven-segment display decoders of the calculator.
- Start/busy/valid handshake; the result is held stable between conversions.

---
 rtl/bcd_result_converter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/bcd_result_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) for the adder result.
// Optional build macro BCD_BLANK_EN adds a registered leading-zero blanking output.
module bcd_result_converter #(
  parameter int N      = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [N-1:0]          sum,
  input  logic                  cout,
  input  logic                  is_signed,
  output logic                  busy,
  output logic                  valid,
  output logic                  neg,
  output logic [4*DIGITS-1:0]   bcd
`ifdef BCD_BLANK_EN
  ,
  output logic [DIGITS-1:0]     blank
`endif
);

  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [N:0]          mag_q, mag_d;
  logic [4*DIGITS-1:0] work_q, work_d;
  logic                neg_work_q, neg_work_d;
  logic                busy_q, busy_d;
  logic                valid_q, valid_d;
  logic                neg_q, neg_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic [N-1:0]        sum_abs;

  // Unary minus of the most negative value wraps to itself, which is the correct unsigned magnitude.
  assign sum_abs = sum[N-1] ? -sum : sum;

  function automatic logic [4*DIGITS-1:0] add3_all(input logic [4*DIGITS-1:0] b);
    logic [4*DIGITS-1:0] r;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = (b[4*i +: 4] >= 4'd5) ? (b[4*i +: 4] + 4'd3) : b[4*i +: 4];
    end
    return r;
  endfunction

`ifdef BCD_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_d;

  function automatic logic [DIGITS-1:0] blank_of(input logic [4*DIGITS-1:0] b);
    logic [DIGITS-1:0] r;
    logic              z;
    r = '0;
    z = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      z    = z & (b[4*i +: 4] == 4'd0);
      r[i] = z;
    end
    return r;
  endfunction

  assign blank = blank_q;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mag_d      = mag_q;
    work_d     = work_q;
    neg_work_d = neg_work_q;
    busy_d     = busy_q;
    valid_d    = 1'b0;
    neg_d      = neg_q;
    bcd_d      = bcd_q;
`ifdef BCD_BLANK_EN
    blank_d    = blank_q;
`endif
    case (state_q)
      S_IDLE: begin
        // A start coinciding with the result pulse is dropped; the next edge may accept one.
        if (start && !valid_q) begin
          if (is_signed) begin
            mag_d      = {1'b0, sum_abs};
            neg_work_d = sum[N-1];
          end else begin
            mag_d      = {cout, sum};
            neg_work_d = 1'b0;
          end
          work_d  = '0;
          cnt_d   = CW'(N);
          busy_d  = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        {work_d, mag_d} = {add3_all(work_q), mag_q} << 1;
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE: begin
        bcd_d   = work_q;
        neg_d   = neg_work_q;
        valid_d = 1'b1;
        busy_d  = 1'b0;
`ifdef BCD_BLANK_EN
        blank_d = blank_of(work_q);
`endif
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      mag_q      <= '0;
      work_q     <= '0;
      neg_work_q <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      neg_q      <= 1'b0;
      bcd_q      <= '0;
`ifdef BCD_BLANK_EN
      blank_q    <= {{(DIGITS-1){1'b1}}, 1'b0};
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mag_q      <= mag_d;
      work_q     <= work_d;
      neg_work_q <= neg_work_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      neg_q      <= neg_d;
      bcd_q      <= bcd_d;
`ifdef BCD_BLANK_EN
      blank_q    <= blank_d;
`endif
    end
  end

  assign busy  = busy_q;
  assign valid = valid_q;
  assign neg   = neg_q;
  assign bcd   = bcd_q;

endmodule
